// File: rtl/shift_register_param_if.sv
// Bundle of control, data and status signals for shift_register_param.
// master drives clear/mode/data, slave (the register) returns outputs and fill status.
interface shift_register_param_if #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 16
);
   localparam int CW = $clog2(DEPTH + 1);

   logic                   clr;
   logic [1:0]             mode;
   logic [WIDTH-1:0]       ser_in;
   logic [WIDTH*DEPTH-1:0] par_in;
   logic [WIDTH-1:0]       ser_out;
   logic [WIDTH*DEPTH-1:0] par_out;
   logic [CW-1:0]          fill_cnt;
   logic                   full;

   modport master (
      output clr, mode, ser_in, par_in,
      input  ser_out, par_out, fill_cnt, full
   );

   modport slave (
      input  clr, mode, ser_in, par_in,
      output ser_out, par_out, fill_cnt, full
   );
endinterface

// File: rtl/shift_register_param.sv
// DEPTH x WIDTH shift register with hold, forward/backward shift, parallel load,
// synchronous clear and a saturating fill counter. Stage 0 is the entry end.
module shift_register_param #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 16
) (
   input logic                   clk,
   input logic                   rst_n,
   shift_register_param_if.slave bus
);
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   typedef enum logic [1:0] {
      MODE_HOLD = 2'b00,
      MODE_FWD  = 2'b01,
      MODE_BWD  = 2'b10,
      MODE_LOAD = 2'b11
   } mode_e;

   logic [DEPTH-1:0][WIDTH-1:0] stage_q, stage_d;
   logic [CW-1:0]               fill_q, fill_d;
   logic [CW-1:0]               fill_inc;

   // Counter tracks entries only and sticks at DEPTH once every stage has been written.
   assign fill_inc = (fill_q == FULL_CNT) ? fill_q : fill_q + CW'(1);

   always_comb begin
      stage_d = stage_q;
      fill_d  = fill_q;
      if (bus.clr) begin
         stage_d = '0;
         fill_d  = '0;
      end else begin
         case (bus.mode)
            MODE_FWD: begin
               stage_d[0] = bus.ser_in;
               for (int i = 1; i < DEPTH; i++) stage_d[i] = stage_q[i-1];
               fill_d = fill_inc;
            end
            MODE_BWD: begin
               stage_d[DEPTH-1] = bus.ser_in;
               for (int i = 0; i < DEPTH - 1; i++) stage_d[i] = stage_q[i+1];
               fill_d = fill_inc;
            end
            MODE_LOAD: begin
               stage_d = bus.par_in;
               fill_d  = FULL_CNT;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stage_q <= '0;
         fill_q  <= '0;
      end else begin
         stage_q <= stage_d;
         fill_q  <= fill_d;
      end
   end

   // Exit end follows the shift direction: stage 0 when shifting backward.
   assign bus.ser_out  = (bus.mode == MODE_BWD) ? stage_q[0] : stage_q[DEPTH-1];
   assign bus.par_out  = stage_q;
   assign bus.fill_cnt = fill_q;
   assign bus.full     = (fill_q == FULL_CNT);
endmodule

// File: tb/tb_shift_register_param.sv
// Directed self-checking bench for shift_register_param using three parameterisations:
// 4x4 for async reset, 1x16 for the delay line, 8x4 for load/shift/hold/clear/saturation.
module tb_shift_register_param;
   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   shift_register_param_if #(.WIDTH(4), .DEPTH(4))  ifa ();
   shift_register_param_if #(.WIDTH(1), .DEPTH(16)) ifb ();
   shift_register_param_if #(.WIDTH(8), .DEPTH(4))  ifc ();

   shift_register_param #(.WIDTH(4), .DEPTH(4))  u_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
   shift_register_param #(.WIDTH(1), .DEPTH(16)) u_b (.clk(clk), .rst_n(rst_n), .bus(ifb));
   shift_register_param #(.WIDTH(8), .DEPTH(4))  u_c (.clk(clk), .rst_n(rst_n), .bus(ifc));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic applyStimulus(input int edges);
      for (int e = 0; e < edges; e++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   initial begin
      logic [7:0] fwd_val [7];
      int         fill_exp [7];
      logic [7:0] ser_exp [7];

      checks   = 0;
      failures = 0;
      fwd_val  = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7};
      fill_exp = '{1, 2, 3, 4, 4, 4, 4};
      ser_exp  = '{8'h00, 8'h00, 8'h00, 8'hA1, 8'hA2, 8'hA3, 8'hA4};

      ifa.clr = 1'b0; ifa.mode = 2'b00; ifa.ser_in = '0; ifa.par_in = '0;
      ifb.clr = 1'b0; ifb.mode = 2'b00; ifb.ser_in = '0; ifb.par_in = '0;
      ifc.clr = 1'b0; ifc.mode = 2'b00; ifc.ser_in = '0; ifc.par_in = '0;
      rst_n = 1'b0;
      applyStimulus(2);
      rst_n = 1'b1;

      checkOutput("init_par_c",  64'(ifc.par_out),  64'h0);
      checkOutput("init_fill_c", 64'(ifc.fill_cnt), 64'd0);
      checkOutput("init_full_b", 64'(ifb.full),     64'd0);

      // Async reset between edges on a fully loaded 4x4 register
      ifa.mode = 2'b11; ifa.par_in = 16'hFFFF;
      applyStimulus(1);
      checkOutput("load_par_a",  64'(ifa.par_out),  64'hFFFF);
      checkOutput("load_fill_a", 64'(ifa.fill_cnt), 64'd4);
      ifa.mode = 2'b00;
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("rst_par_a",  64'(ifa.par_out),  64'h0);
      checkOutput("rst_fill_a", 64'(ifa.fill_cnt), 64'd0);
      checkOutput("rst_full_a", 64'(ifa.full),     64'd0);
      checkOutput("rst_ser_a",  64'(ifa.ser_out),  64'h0);
      applyStimulus(1);
      rst_n = 1'b1;

      // One-hot pulse through the 16-stage delay line
      ifb.mode = 2'b01; ifb.ser_in = 1'b1;
      applyStimulus(1);
      ifb.ser_in = 1'b0;
      checkOutput("dl_ser_e1",  64'(ifb.ser_out),  64'd0);
      checkOutput("dl_fill_e1", 64'(ifb.fill_cnt), 64'd1);
      for (int e = 2; e <= 17; e++) begin
         applyStimulus(1);
         checkOutput($sformatf("dl_ser_e%0d", e),  64'(ifb.ser_out), (e == 16) ? 64'd1 : 64'd0);
         checkOutput($sformatf("dl_full_e%0d", e), 64'(ifb.full),    (e >= 16) ? 64'd1 : 64'd0);
      end
      checkOutput("dl_fill_sat", 64'(ifb.fill_cnt), 64'd16);
      ifb.mode = 2'b00;

      // Parallel load then one backward shift on the 8x4 register
      ifc.mode = 2'b11; ifc.par_in = 32'h44332211;
      applyStimulus(1);
      checkOutput("pl_par",  64'(ifc.par_out),  64'h44332211);
      checkOutput("pl_fill", 64'(ifc.fill_cnt), 64'd4);
      checkOutput("pl_full", 64'(ifc.full),     64'd1);
      checkOutput("pl_ser",  64'(ifc.ser_out),  64'h44);
      ifc.mode = 2'b10; ifc.ser_in = 8'hAA;
      #1;
      checkOutput("bwd_ser_sel", 64'(ifc.ser_out), 64'h11);
      applyStimulus(1);
      checkOutput("bwd_par",  64'(ifc.par_out),  64'hAA443322);
      checkOutput("bwd_ser",  64'(ifc.ser_out),  64'h22);
      checkOutput("bwd_fill", 64'(ifc.fill_cnt), 64'd4);

      // Hold for 10 edges with a toggling serial input
      ifc.mode = 2'b00;
      for (int e = 0; e < 10; e++) begin
         ifc.ser_in = (e % 2 == 0) ? 8'h55 : 8'hAA;
         applyStimulus(1);
      end
      checkOutput("hold_par",  64'(ifc.par_out),  64'hAA443322);
      checkOutput("hold_fill", 64'(ifc.fill_cnt), 64'd4);
      checkOutput("hold_ser",  64'(ifc.ser_out),  64'hAA);

      // Clear beats a simultaneous parallel load
      ifc.clr = 1'b1; ifc.mode = 2'b11; ifc.par_in = '1;
      applyStimulus(1);
      ifc.clr = 1'b0;
      checkOutput("clr_par",  64'(ifc.par_out),  64'h0);
      checkOutput("clr_fill", 64'(ifc.fill_cnt), 64'd0);
      checkOutput("clr_full", 64'(ifc.full),     64'd0);

      // Seven forward shifts: fill saturates at 4, output delayed by 4 edges
      ifc.mode = 2'b01;
      for (int k = 0; k < 7; k++) begin
         ifc.ser_in = fwd_val[k];
         applyStimulus(1);
         checkOutput($sformatf("sat_fill_%0d", k), 64'(ifc.fill_cnt), 64'(fill_exp[k]));
         checkOutput($sformatf("sat_full_%0d", k), 64'(ifc.full),     (k >= 3) ? 64'd1 : 64'd0);
         checkOutput($sformatf("sat_ser_%0d", k),  64'(ifc.ser_out),  64'(ser_exp[k]));
      end
      checkOutput("sat_par", 64'(ifc.par_out), 64'hA4A5A6A7);

      // Backward shift after clear also counts as an entry
      ifc.clr = 1'b1;
      applyStimulus(1);
      ifc.clr = 1'b0; ifc.mode = 2'b10; ifc.ser_in = 8'h5C;
      applyStimulus(1);
      checkOutput("bwd1_fill", 64'(ifc.fill_cnt), 64'd1);
      checkOutput("bwd1_par",  64'(ifc.par_out),  64'h5C000000);
      checkOutput("bwd1_ser",  64'(ifc.ser_out),  64'h00);
      ifc.mode = 2'b00;
      #1;
      checkOutput("hold_exit", 64'(ifc.ser_out), 64'h5C);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
